// File: rtl/nn_layer_sequencer.sv
// Forward-propagation sequencer for the layered neuron datapath.
// Walks 1..NUM_LAYERS layers through a LOAD phase (MAC accumulation over the
// layer inputs) and an ACT phase (sigmoid over the layer outputs), publishing
// the shared Tick index used to address the weight and input memories.
// Per-layer counts are latched when a pass starts; a pass can be aborted.
module nn_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int TICK_W     = 10,
    parameter int LEAD       = 2,
    parameter int PIPE_LAT   = 4
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           Compute,
    input  logic                           Abort,
    input  logic [NUM_LAYERS*TICK_W-1:0]   CfgIn,
    input  logic [NUM_LAYERS*TICK_W-1:0]   CfgOut,
    output logic [NUM_LAYERS-1:0]          Layer,
    output logic [2:0]                     LayerIdx,
    output logic [NUM_LAYERS-1:0]          Active,
    output logic [TICK_W-1:0]              Tick,
    output logic                           ActFuncActive,
    output logic                           Busy,
    output logic                           R,
    output logic                           DonePulse,
    output logic                           Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_ACT,
        S_DONE
    } state_e;

    localparam logic [TICK_W-1:0] LEAD_T  = TICK_W'(LEAD);
    localparam logic [TICK_W-1:0] PIPE_T  = TICK_W'(PIPE_LAT);
    localparam logic [TICK_W-1:0] ONE_T   = TICK_W'(1);
    localparam logic [2:0]        LAST_IX = 3'(NUM_LAYERS - 1);
    localparam int unsigned       MAX_LEN = (32'd1 << TICK_W) - 32'd1;

    state_e                         state_q;
    logic [TICK_W-1:0]              tick_q;
    logic [2:0]                     idx_q;
    logic                           compute_q;
    logic                           armed_q;
    logic                           r_q;
    logic                           err_q;
    logic                           done_pulse_q;
    logic [NUM_LAYERS*TICK_W-1:0]   cfg_in_q;
    logic [NUM_LAYERS*TICK_W-1:0]   cfg_out_q;

    logic [TICK_W-1:0]              cur_in;
    logic [TICK_W-1:0]              cur_out;
    logic [TICK_W-1:0]              len_in;
    logic [TICK_W-1:0]              len_act;
    logic [NUM_LAYERS-1:0]          onehot;
    logic                           load_last;
    logic                           act_last;
    logic                           cfg_err;
    logic                           start;

    // Select the latched counts of the current layer and derive phase lengths.
    always_comb begin
        cur_in  = '0;
        cur_out = '0;
        onehot  = '0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            if (idx_q == 3'(l)) begin
                cur_in    = cfg_in_q[l*TICK_W +: TICK_W];
                cur_out   = cfg_out_q[l*TICK_W +: TICK_W];
                onehot[l] = 1'b1;
            end
        end
        // Lengths were range-checked at start, so they fit in TICK_W bits.
        len_in    = LEAD_T + cur_in + PIPE_T;
        len_act   = LEAD_T + cur_out;
        load_last = (tick_q == len_in - ONE_T);
        act_last  = (tick_q == len_act - ONE_T);
    end

    // Any layer whose LOAD or ACT length cannot be counted by Tick is an error.
    always_comb begin
        cfg_err = 1'b0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            if ((32'(LEAD) + 32'(CfgIn[l*TICK_W +: TICK_W]) + 32'(PIPE_LAT) > MAX_LEN) ||
                (32'(LEAD) + 32'(CfgOut[l*TICK_W +: TICK_W]) > MAX_LEN)) begin
                cfg_err = 1'b1;
            end
        end
    end

    // A start needs a fresh rising edge; armed_q blocks a level held through reset.
    assign start = Compute && !compute_q && armed_q;

    // Sequencer state, counters, completion flags and configuration latches.
    // NOTE: every register here, the configuration latches included, is a
    // control flop with a defined reset value, so all updates use <= to keep
    // each cycle's decisions based on the values from the previous edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            idx_q        <= '0;
            compute_q    <= 1'b0;
            armed_q      <= 1'b0;
            r_q          <= 1'b0;
            err_q        <= 1'b0;
            done_pulse_q <= 1'b0;
            cfg_in_q     <= '0;
            cfg_out_q    <= '0;
        end else begin
            compute_q    <= Compute;
            done_pulse_q <= 1'b0;
            if (!Compute) begin
                armed_q <= 1'b1;
            end
            if (Abort && (state_q == S_START || state_q == S_LOAD || state_q == S_ACT)) begin
                state_q <= S_IDLE;
                tick_q  <= '0;
                idx_q   <= '0;
                r_q     <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_START;
                        end
                    end
                    S_START: begin
                        cfg_in_q  <= CfgIn;
                        cfg_out_q <= CfgOut;
                        tick_q    <= '0;
                        idx_q     <= '0;
                        if (cfg_err) begin
                            state_q      <= S_DONE;
                            r_q          <= 1'b1;
                            err_q        <= 1'b1;
                            done_pulse_q <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            r_q     <= 1'b0;
                            err_q   <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        if (load_last) begin
                            state_q <= S_ACT;
                            tick_q  <= '0;
                        end else begin
                            tick_q <= tick_q + ONE_T;
                        end
                    end
                    S_ACT: begin
                        if (!act_last) begin
                            tick_q <= tick_q + ONE_T;
                        end else if (idx_q == LAST_IX) begin
                            state_q      <= S_DONE;
                            tick_q       <= '0;
                            idx_q        <= '0;
                            r_q          <= 1'b1;
                            done_pulse_q <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            tick_q  <= '0;
                            idx_q   <= idx_q + 3'd1;
                        end
                    end
                    S_DONE: begin
                        tick_q <= '0;
                        idx_q  <= '0;
                        if (!Compute) begin
                            state_q <= S_IDLE;
                            r_q     <= 1'b0;
                            err_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Enables decode purely from registered state, Tick and LayerIdx.
    always_comb begin
        Layer         = '0;
        Active        = '0;
        ActFuncActive = 1'b0;
        if (state_q == S_LOAD && !load_last) begin
            Layer = onehot;
            if (tick_q >= LEAD_T && tick_q < LEAD_T + cur_in) begin
                Active = onehot;
            end
        end
        if (state_q == S_ACT) begin
            Layer         = onehot;
            ActFuncActive = (tick_q >= LEAD_T);
        end
    end

    assign Busy      = (state_q == S_START) || (state_q == S_LOAD) || (state_q == S_ACT);
    assign Tick      = tick_q;
    assign LayerIdx  = idx_q;
    assign R         = r_q;
    assign Err       = err_q;
    assign DonePulse = done_pulse_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: a pass-level reference model
// expands each layer configuration into the expected per-cycle output trace,
// and a monitor compares every cycle in which the sequencer is busy or
// pulses done against that trace.
module tb_nn_layer_sequencer;

    localparam int NL   = 3;
    localparam int TW   = 10;
    localparam int LEAD = 2;
    localparam int PIPE = 4;
    localparam int MAXL = (1 << TW) - 1;

    typedef struct packed {
        logic [NL-1:0] layer;
        logic [2:0]    idx;
        logic [NL-1:0] active;
        logic [TW-1:0] tick;
        logic          afa;
        logic          busy;
        logic          r;
        logic          pulse;
        logic          err;
    } rec_t;

    logic               Clk = 1'b0;
    logic               Reset_n;
    logic               Compute;
    logic               Abort;
    logic [NL*TW-1:0]   CfgIn;
    logic [NL*TW-1:0]   CfgOut;
    logic [NL-1:0]      Layer;
    logic [2:0]         LayerIdx;
    logic [NL-1:0]      Active;
    logic [TW-1:0]      Tick;
    logic               ActFuncActive;
    logic               Busy;
    logic               R;
    logic               DonePulse;
    logic               Err;

    // Single-layer instance for the one-layer, zero-count corner.
    logic               Compute1;
    logic               Abort1;
    logic [TW-1:0]      CfgIn1;
    logic [TW-1:0]      CfgOut1;
    logic [0:0]         Layer1;
    logic [2:0]         LayerIdx1;
    logic [0:0]         Active1;
    logic [TW-1:0]      Tick1;
    logic               ActFuncActive1;
    logic               Busy1;
    logic               R1;
    logic               DonePulse1;
    logic               Err1;

    int   checks   = 0;
    int   failures = 0;
    rec_t exp_q[$];
    rec_t mon_act;
    rec_t mon_exp;

    nn_layer_sequencer #(.NUM_LAYERS(NL), .TICK_W(TW), .LEAD(LEAD), .PIPE_LAT(PIPE)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Compute(Compute), .Abort(Abort),
        .CfgIn(CfgIn), .CfgOut(CfgOut), .Layer(Layer), .LayerIdx(LayerIdx),
        .Active(Active), .Tick(Tick), .ActFuncActive(ActFuncActive), .Busy(Busy),
        .R(R), .DonePulse(DonePulse), .Err(Err)
    );

    nn_layer_sequencer #(.NUM_LAYERS(1), .TICK_W(TW), .LEAD(LEAD), .PIPE_LAT(PIPE)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Compute(Compute1), .Abort(Abort1),
        .CfgIn(CfgIn1), .CfgOut(CfgOut1), .Layer(Layer1), .LayerIdx(LayerIdx1),
        .Active(Active1), .Tick(Tick1), .ActFuncActive(ActFuncActive1), .Busy(Busy1),
        .R(R1), .DonePulse(DonePulse1), .Err(Err1)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NL*TW-1:0] pack3(input int c0, input int c1, input int c2);
        return {TW'(c2), TW'(c1), TW'(c0)};
    endfunction

    // Reference model: expands one pass into its cycle-by-cycle trace.
    // abort_req: -1 = run to completion, -2 = random abort point, >=0 = abort
    // during that trace cycle. Pushes the records the DUT is expected to show.
    task automatic push_pass(input logic [NL*TW-1:0] cin, input logic [NL*TW-1:0] cout,
                             input int abort_req, output int abort_at);
        rec_t tr[$];
        rec_t r;
        bit   bad = 1'b0;
        for (int l = 0; l < NL; l++) begin
            if (LEAD + int'(cin[l*TW +: TW]) + PIPE > MAXL) bad = 1'b1;
            if (LEAD + int'(cout[l*TW +: TW]) > MAXL) bad = 1'b1;
        end
        r = '0;
        r.busy = 1'b1;
        tr.push_back(r);                        // START
        if (!bad) begin
            for (int l = 0; l < NL; l++) begin
                int ci   = int'(cin[l*TW +: TW]);
                int co   = int'(cout[l*TW +: TW]);
                int lin  = LEAD + ci + PIPE;
                int lact = LEAD + co;
                for (int t = 0; t < lin; t++) begin
                    r = '0;
                    r.busy = 1'b1;
                    r.idx  = 3'(l);
                    r.tick = TW'(t);
                    if (t != lin - 1) r.layer = NL'(1 << l);
                    if (t != lin - 1 && t >= LEAD && t <= LEAD + ci - 1) r.active = NL'(1 << l);
                    tr.push_back(r);
                end
                for (int t = 0; t < lact; t++) begin
                    r = '0;
                    r.busy  = 1'b1;
                    r.idx   = 3'(l);
                    r.tick  = TW'(t);
                    r.layer = NL'(1 << l);
                    r.afa   = (t >= LEAD);
                    tr.push_back(r);
                end
            end
        end
        abort_at = abort_req;
        if (abort_req == -2) begin
            if (!bad && ($urandom_range(0, 3) == 0)) abort_at = $urandom_range(1, tr.size() - 1);
            else abort_at = -1;
        end
        r = '0;
        r.r     = 1'b1;
        r.pulse = 1'b1;
        r.err   = bad;
        tr.push_back(r);                        // first DONE cycle
        foreach (tr[i]) begin
            if (abort_at < 0 || i <= abort_at) exp_q.push_back(tr[i]);
        end
    endtask

    // Monitor: every busy or done-pulse cycle must match the next expected record.
    always @(negedge Clk) begin
        if (Reset_n && (Busy || DonePulse)) begin
            mon_act = '{Layer, LayerIdx, Active, Tick, ActFuncActive, Busy, R, DonePulse, Err};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0h with no expected record (t=%0t)", mon_act, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("trace", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge Clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic run_pass(input logic [NL*TW-1:0] cin, input logic [NL*TW-1:0] cout,
                            input int abort_req);
        int ab;
        @(posedge Clk);
        #1;
        CfgIn  = cin;
        CfgOut = cout;
        push_pass(cin, cout, abort_req, ab);
        Compute = 1'b1;
        @(posedge Clk);                         // start edge: START cycle follows
        @(posedge Clk);                         // configuration latched
        #1;
        CfgIn  = (NL*TW)'($urandom);
        CfgOut = (NL*TW)'($urandom);
        if (ab >= 1) begin
            repeat (ab - 1) @(posedge Clk);
            #1 Abort = 1'b1;
            @(posedge Clk);
            #1 Abort = 1'b0;
            check("abort_busy", 64'(Busy), 64'(0));
            check("abort_r", 64'({R, DonePulse, Err}), 64'(0));
            check("abort_tick_idx", 64'({Tick, LayerIdx}), 64'(0));
            check("abort_enables", 64'({Layer, Active, ActFuncActive}), 64'(0));
            check("abort_queue", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
            repeat (4) @(posedge Clk);
            #1;
            check("no_restart", 64'(Busy), 64'(0));
            Compute = 1'b0;
        end else begin
            wait_drain(2500);
            repeat (2) @(posedge Clk);
            #1;
            check("r_hold", 64'({R, DonePulse, Busy}), 64'(3'b100));
            Compute = 1'b0;
            @(posedge Clk);
            #1;
            check("r_clear", 64'(R), 64'(0));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int ab;
        int done_at;
        int seen;
        int lcnt;
        Reset_n  = 1'b0;
        Compute  = 1'b0;
        Abort    = 1'b0;
        CfgIn    = '0;
        CfgOut   = '0;
        Compute1 = 1'b0;
        Abort1   = 1'b0;
        CfgIn1   = '0;
        CfgOut1  = '0;
        #3;
        check("rst_tick", 64'(Tick), 64'(0));
        check("rst_idx", 64'(LayerIdx), 64'(0));
        check("rst_flags", 64'({R, Err, DonePulse, Busy}), 64'(0));
        check("rst_enables", 64'({Layer, Active, ActFuncActive}), 64'(0));
        #20 Reset_n = 1'b1;

        // Reference network, full pass.
        run_pass(pack3(784, 20, 20), pack3(20, 20, 10), -1);
        // Abort during LOAD of layer 1 at Tick 10.
        run_pass(pack3(784, 20, 20), pack3(20, 20, 10), 1 + 790 + 22 + 10);
        // Over-long layer 0 is a configuration error.
        run_pass(pack3(1020, 20, 20), pack3(20, 20, 10), -1);
        // Randomized passes, including zero counts, errors and aborts.
        for (int n = 0; n < 14; n++) begin
            int c[6];
            foreach (c[i]) begin
                c[i] = $urandom_range(0, 30);
                if ($urandom_range(0, 15) == 0) c[i] = $urandom_range(1016, 1023);
            end
            run_pass(pack3(c[0], c[1], c[2]), pack3(c[3], c[4], c[5]), -2);
        end

        // Asynchronous reset in ACT of layer 2 with Compute held high.
        @(posedge Clk);
        #1;
        CfgIn  = pack3(784, 20, 20);
        CfgOut = pack3(20, 20, 10);
        push_pass(CfgIn, CfgOut, 1 + 812 + 48 + 26 + 5, ab);
        Compute = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        CfgIn = (NL*TW)'($urandom);
        repeat (ab - 1) @(posedge Clk);
        @(negedge Clk);
        #2;
        check("pre_reset_queue", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        Reset_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(Busy), 64'(0));
        check("async_rst_enables", 64'({Layer, Active, ActFuncActive}), 64'(0));
        check("async_rst_tick_idx", 64'({Tick, LayerIdx}), 64'(0));
        #13 Reset_n = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        check("no_start_after_reset", 64'({Busy, R, Layer}), 64'(0));
        Compute = 1'b0;

        // One layer with zero input and output counts.
        @(posedge Clk);
        #1 Compute1 = 1'b1;
        @(posedge Clk);
        done_at = -1;
        seen    = 0;
        lcnt    = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge Clk);
            if (Active1 != 1'b0 || ActFuncActive1) seen++;
            if (Layer1 != 1'b0) lcnt++;
            if (DonePulse1) begin
                done_at = n;
                break;
            end
        end
        check("one_layer_done_at", 64'(done_at), 64'(1 + 6 + 2));
        check("one_layer_enables", 64'(seen), 64'(0));
        check("one_layer_layer_cycles", 64'(lcnt), 64'(5 + 2));
        check("one_layer_r", 64'({R1, Err1}), 64'(2'b10));
        #1 Compute1 = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("one_layer_r_clear", 64'(R1), 64'(0));

        check("final_queue", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
